// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider producing clk_out plus a one-cycle tick.
// Optional fixed prescaler enabled by defining CLKDIV_PRESCALE_EN (period becomes D * 2^PRESCALE_LOG2).
module clk_divider_prog #(
    parameter int WIDTH         = 16,
    parameter int DIV_RESET     = 512,
    parameter int PRESCALE_LOG2 = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             div_wr,
    input  logic [WIDTH-1:0] div_in,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic             div_pending,
    output logic [WIDTH-1:0] div_active
);

    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TWO     = {{(WIDTH-2){1'b0}}, 2'b10};
    localparam logic [WIDTH-1:0] DIV_RST = (DIV_RESET < 2) ? TWO : DIV_RESET[WIDTH-1:0];

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
        if (d < TWO) begin
            return TWO;
        end else begin
            return d;
        end
    endfunction

    state_t           state_r, state_n;
    logic [WIDTH-1:0] cnt_r, cnt_n;
    logic             clk_out_r, clk_out_n;
    logic             tick_r, tick_n;
    logic [WIDTH-1:0] div_active_r, div_active_n;
    logic [WIDTH-1:0] pend_r, pend_n;
    logic             pend_flag_r, pend_flag_n;

    logic             psc_done_s;
    logic             step_s;
    logic             wrap_s;
    logic             apply_s;
    logic [WIDTH-1:0] half_s;
    logic [WIDTH-1:0] low_s;
    logic [WIDTH-1:0] cnt_inc_s;

`ifdef CLKDIV_PRESCALE_EN
    localparam int PSW = (PRESCALE_LOG2 > 0) ? PRESCALE_LOG2 : 1;
    localparam logic [PSW-1:0] PS_MAX = PSW'((32'd1 << PRESCALE_LOG2) - 32'd1);
    localparam logic [PSW-1:0] PS_ONE = {{(PSW-1){1'b0}}, 1'b1};

    logic [PSW-1:0] psc_r, psc_n;

    // Prescale counter: free-runs while counting, cleared whenever the divider is (or becomes) idle.
    always_comb begin
        psc_done_s = (psc_r == PS_MAX);
        psc_n      = {PSW{1'b0}};
        if ((state_r == ST_RUN) && (state_n == ST_RUN)) begin
            if (psc_done_s) begin
                psc_n = {PSW{1'b0}};
            end else begin
                psc_n = psc_r + PS_ONE;
            end
        end else begin
            psc_n = {PSW{1'b0}};
        end
    end

    // Prescale counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            psc_r <= {PSW{1'b0}};
        end else begin
            psc_r <= psc_n;
        end
    end
`else
    assign psc_done_s = 1'b1;
`endif

    assign step_s    = (state_r == ST_RUN) && psc_done_s;
    assign wrap_s    = step_s && (cnt_r == (div_active_r - ONE));
    assign half_s    = div_active_r >> 1;
    assign low_s     = div_active_r - half_s;
    assign cnt_inc_s = wrap_s ? ZERO : (cnt_r + ONE);

    // Next-state logic: period counting, stop at the wrap edge, divisor apply and capture.
    always_comb begin
        state_n      = state_r;
        cnt_n        = cnt_r;
        clk_out_n    = clk_out_r;
        tick_n       = 1'b0;
        div_active_n = div_active_r;
        pend_n       = pend_r;
        pend_flag_n  = pend_flag_r;
        apply_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                cnt_n     = ZERO;
                clk_out_n = 1'b0;
                apply_s   = pend_flag_r;
                if (en) begin
                    state_n = ST_RUN;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (step_s) begin
                    cnt_n     = cnt_inc_s;
                    clk_out_n = (cnt_inc_s >= low_s);
                    tick_n    = !clk_out_r && (cnt_inc_s >= low_s);
                    if (wrap_s) begin
                        apply_s = pend_flag_r;
                        if (!en) begin
                            state_n   = ST_IDLE;
                            cnt_n     = ZERO;
                            clk_out_n = 1'b0;
                        end else begin
                            state_n = ST_RUN;
                        end
                    end else begin
                        state_n = ST_RUN;
                    end
                end else begin
                    state_n = ST_RUN;
                end
            end
            default: begin
                state_n   = ST_IDLE;
                cnt_n     = ZERO;
                clk_out_n = 1'b0;
            end
        endcase

        // A write in the same cycle as an apply lands in the pending slot for the next opportunity.
        if (apply_s) begin
            div_active_n = pend_r;
            pend_flag_n  = 1'b0;
        end else begin
            div_active_n = div_active_r;
        end
        if (div_wr) begin
            pend_n      = clamp_div(div_in);
            pend_flag_n = 1'b1;
        end else begin
            pend_n = pend_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= ZERO;
            clk_out_r    <= 1'b0;
            tick_r       <= 1'b0;
            div_active_r <= DIV_RST;
            pend_r       <= ZERO;
            pend_flag_r  <= 1'b0;
        end else begin
            state_r      <= state_n;
            cnt_r        <= cnt_n;
            clk_out_r    <= clk_out_n;
            tick_r       <= tick_n;
            div_active_r <= div_active_n;
            pend_r       <= pend_n;
            pend_flag_r  <= pend_flag_n;
        end
    end

    assign clk_out     = clk_out_r;
    assign tick        = tick_r;
    assign running     = (state_r == ST_RUN);
    assign div_pending = pend_flag_r;
    assign div_active  = div_active_r;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Scoreboard bench for clk_divider_prog: a time-position model pushes expected outputs per cycle,
// a monitor pops and compares them after each clock edge.
module tb_clk_divider_prog;

    localparam int W = 16;
`ifdef CLKDIV_PRESCALE_EN
    localparam int P = 2;
`else
    localparam int P = 0;
`endif
    localparam int S = 1 << P;

    typedef logic [W+3:0] exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic         div_wr = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         clk_out, tick, running, div_pending;
    logic [W-1:0] div_active;

    clk_divider_prog #(.WIDTH(W), .DIV_RESET(512), .PRESCALE_LOG2(P)) dut (
        .clk(clk), .reset(reset), .en(en), .div_wr(div_wr), .div_in(div_in),
        .clk_out(clk_out), .tick(tick), .running(running),
        .div_pending(div_pending), .div_active(div_active)
    );

    always #5 clk = ~clk;

    // Model state: k is the number of clk edges elapsed in the current period.
    int   mdiv = 512, mpend = 0, mk = 0;
    bit   mflag = 1'b0, mrun = 1'b0;
    exp_t q[$];
    int   total = 0, bad = 0, cyc_no = 0;
    bit   started = 1'b0;

    function automatic int clamp2(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic exp_t model_out();
        int  low_edges;
        bit  hi, tk;
        logic [W-1:0] dv;
        low_edges = (mdiv - mdiv / 2) * S;
        hi = mrun && (mk >= low_edges);
        tk = mrun && (mk == low_edges);
        dv = mdiv[W-1:0];
        return {hi, tk, mrun, mflag, dv};
    endfunction

    task automatic model_step(input bit e, input bit w, input int din, input bit r);
        bit apply;
        apply = 1'b0;
        if (r) begin
            mdiv = 512; mpend = 0; mflag = 1'b0; mrun = 1'b0; mk = 0;
        end else begin
            if (mrun) begin
                if (mk == mdiv * S - 1) begin
                    mk = 0;
                    apply = mflag;
                    if (!e) mrun = 1'b0;
                end else begin
                    mk++;
                end
            end else begin
                apply = mflag;
                if (e) begin
                    mrun = 1'b1;
                    mk = 0;
                end
            end
            if (apply) begin
                mdiv = mpend;
                mflag = 1'b0;
            end
            if (w) begin
                mpend = clamp2(din);
                mflag = 1'b1;
            end
        end
    endtask

    task automatic cyc(input bit e, input bit w, input int din, input bit r);
        @(negedge clk);
        en = e; div_wr = w; div_in = din[W-1:0]; reset = r;
        model_step(e, w, din, r);
        q.push_back(model_out());
        started = 1'b1;
    endtask

    task automatic rn(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic wait_k(input int target, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (mrun && mk == target) return;
            cyc(1'b1, 1'b0, 0, 1'b0);
        end
        total++; bad++;
        $display("FAIL wait_k timeout got k=%0d want k=%0d", mk, target);
    endtask

    // Monitor: one scoreboard entry per clock edge.
    initial begin
        exp_t e;
        exp_t g;
        wait (started);
        forever begin
            @(posedge clk);
            #1;
            cyc_no++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL queue_empty at cycle %0d got=nothing want=entry", cyc_no);
            end else begin
                e = q.pop_front();
                g = {clk_out, tick, running, div_pending, div_active};
                if (g !== e) begin
                    bad++;
                    $display("FAIL outputs cycle=%0d got clk_out=%b tick=%b running=%b pending=%b div=%0d want clk_out=%b tick=%b running=%b pending=%b div=%0d",
                             cyc_no, g[W+3], g[W+2], g[W+1], g[W], g[W-1:0],
                             e[W+3], e[W+2], e[W+1], e[W], e[W-1:0]);
                end
            end
        end
    end

    initial begin
        // Reset state, then default divide-by-512.
        cyc(1'b0, 1'b0, 0, 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b1);
        rn(1100 * S);

        // Mid-period write of 5 at cnt=100.
        wait_k(100 * S, 600 * S);
        cyc(1'b1, 1'b1, 5, 1'b0);
        rn(480 * S);

        // Clamping of 0 and 1.
        cyc(1'b1, 1'b1, 0, 1'b0);
        rn(20 * S);
        cyc(1'b1, 1'b1, 1, 1'b0);
        rn(20 * S);

        // Stop/restart with D=10, dropping en at cnt=3.
        cyc(1'b1, 1'b1, 10, 1'b0);
        rn(30 * S);
        wait_k(3 * S, 40 * S);
        for (int i = 0; i < 20 * S; i++) cyc(1'b0, 1'b0, 0, 1'b0);
        rn(30 * S);

        // en dips and returns before the wrap: no interruption.
        wait_k(2 * S, 40 * S);
        cyc(1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b0);
        rn(30 * S);

        // Write coinciding with the wrap edge waits for the next wrap.
        wait_k(10 * S - 1, 40 * S);
        cyc(1'b1, 1'b1, 6, 1'b0);
        rn(40 * S);

        // Write while stopped applies on the following edge.
        wait_k(6 * S - 1, 40 * S);
        cyc(1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b1, 3, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b0);
        rn(20 * S);

        // Reset while clk_out high and a divisor pending.
        cyc(1'b1, 1'b1, 9, 1'b0);
        rn(10 * S);
        for (int i = 0; i < 40 * S; i++) begin
            if (mrun && model_out() >= exp_t'(1) << (W + 3)) break;
            cyc(1'b1, 1'b0, 0, 1'b0);
        end
        cyc(1'b1, 1'b1, 7, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b1);
        rn(20);

        // Randomized traffic with small divisors.
        cyc(1'b1, 1'b1, 4, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            bit e, w, r;
            int d;
            e = ($urandom_range(0, 7) != 0);
            w = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 299) == 0);
            d = $urandom_range(0, 12);
            cyc(e, w, d, r);
        end

        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
